serial_adder: RTL

Bit-serial adder built around the team's single-bit `fa` full-adder cell. It adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, with a registered carry between cycles. It sits directly upstream of `fa`, feeding it one operand-bit pair and the stored carry each cycle and consuming its `sum`/`cout`. A start/busy/done handshake connects it to a controller.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_fa.sv | 16 +
 rtl/serial_adder.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Pure combinational sum and carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Bit 0 of the partial result is never needed again once shifted out,
  // so the register only keeps the upper WIDTH-1 bits.
  logic [WIDTH-1:1] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state decode and start acceptance (only in IDLE or DONE).
  always_comb begin
    next   = state;
    accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          next   = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) next = DONE;
      end
      DONE: begin
        if (start) begin
          accept = 1'b1;
          next   = RUN;
        end else begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next[WIDTH-1:1];
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      if (cnt == LAST) begin
        sum  <= res_next;
        cout <= fa_cout;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
